// File: rtl/square_bounce.sv
// square_bounce: square sprite that moves inside the playfield supplied by the
// border stage and bounces off its edges.
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_ani_stb          one-cycle animation strobe per frame
//   i_animate          motion enable (square frozen when low)
//   i_bl/i_br/i_bt/i_bb  playfield inner edges (min x, max x, min y, max y)
//   o_l/o_r/o_t/o_b    square edges derived from the centre position
//   o_hit              one-cycle pulse on any border contact
//   o_corner           one-cycle pulse when both axes make contact together
//   o_hit_cnt          wrapping count of contact steps
module square_bounce #(
  parameter int unsigned H_SIZE = 20,
  parameter int unsigned IX     = 320,
  parameter int unsigned IY     = 240,
  parameter int unsigned IX_DIR = 1,
  parameter int unsigned IY_DIR = 1,
  parameter int unsigned SPEED  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic [11:0] i_bl,
  input  logic [11:0] i_br,
  input  logic [11:0] i_bt,
  input  logic [11:0] i_bb,
  output logic [11:0] o_l,
  output logic [11:0] o_r,
  output logic [11:0] o_t,
  output logic [11:0] o_b,
  output logic        o_hit,
  output logic        o_corner,
  output logic [7:0]  o_hit_cnt
);

  localparam int unsigned W  = 12;
  localparam int unsigned CW = W + 1;

  localparam logic [CW-1:0] C_H  = CW'(H_SIZE);
  localparam logic [CW-1:0] C_S  = CW'(SPEED);
  localparam logic [CW-1:0] C_2H = CW'(2 * H_SIZE);
  localparam logic [W-1:0]  P_H  = W'(H_SIZE);
  localparam logic [W-1:0]  P_S  = W'(SPEED);

  logic [W-1:0] r_x, r_y;
  logic         r_x_dir, r_y_dir;

  logic [W-1:0] w_x_nxt, w_y_nxt;
  logic         w_x_dir_nxt, w_y_dir_nxt;
  logic         w_h_contact, w_v_contact;
  logic         w_step;

  // One axis step: returns {contact, next_dir, next_pos}. Comparisons are done
  // on 13-bit zero-extended values so edge sums never wrap.
  function automatic logic [W+1:0] axis_step(
    input logic [W-1:0] pos,
    input logic         dir,
    input logic [W-1:0] lo,
    input logic [W-1:0] hi
  );
    logic [W-1:0] n_pos;
    logic         n_dir;
    logic         hit;
    n_pos = pos;
    n_dir = dir;
    hit   = 1'b0;
    // A playfield narrower than the square freezes the axis entirely.
    if ({1'b0, hi} >= {1'b0, lo} + C_2H) begin
      if (dir) begin
        if ({1'b0, pos} + C_S + C_H >= {1'b0, hi}) begin
          n_pos = hi - P_H;
          n_dir = 1'b0;
          hit   = 1'b1;
        end else begin
          n_pos = pos + P_S;
        end
      end else begin
        if ({1'b0, pos} <= {1'b0, lo} + C_H + C_S) begin
          n_pos = lo + P_H;
          n_dir = 1'b1;
          hit   = 1'b1;
        end else begin
          n_pos = pos - P_S;
        end
      end
    end
    return {hit, n_dir, n_pos};
  endfunction

  assign w_step = i_ani_stb & i_animate;

  // Candidate next position/direction for both axes.
  always_comb begin
    {w_h_contact, w_x_dir_nxt, w_x_nxt} = axis_step(r_x, r_x_dir, i_bl, i_br);
    {w_v_contact, w_y_dir_nxt, w_y_nxt} = axis_step(r_y, r_y_dir, i_bt, i_bb);
  end

  // Position, direction and contact reporting registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x       <= W'(IX);
      r_y       <= W'(IY);
      r_x_dir   <= 1'(IX_DIR);
      r_y_dir   <= 1'(IY_DIR);
      o_hit     <= 1'b0;
      o_corner  <= 1'b0;
      o_hit_cnt <= 8'd0;
    end else if (w_step) begin
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_x_dir  <= w_x_dir_nxt;
      r_y_dir  <= w_y_dir_nxt;
      o_hit    <= w_h_contact | w_v_contact;
      o_corner <= w_h_contact & w_v_contact;
      if (w_h_contact | w_v_contact) begin
        o_hit_cnt <= o_hit_cnt + 8'd1;
      end
    end else begin
      o_hit    <= 1'b0;
      o_corner <= 1'b0;
    end
  end

  // Edges follow the registered centre directly.
  assign o_l = r_x - P_H;
  assign o_r = r_x + P_H;
  assign o_t = r_y - P_H;
  assign o_b = r_y + P_H;

endmodule

// File: tb/tb_square_bounce.sv
// Testbench for square_bounce: three instances (default, lower-left start,
// fast start near the right edge) share stimulus and are checked against a
// behavioural model of the bounce rules.
module tb_square_bounce;

  localparam int NI = 3;
  localparam int H  = 20;

  logic        clk;
  logic        i_rst;
  logic        i_ani_stb;
  logic        i_animate;
  logic [11:0] i_bl, i_br, i_bt, i_bb;

  logic [11:0] w_l [NI];
  logic [11:0] w_r [NI];
  logic [11:0] w_t [NI];
  logic [11:0] w_b [NI];
  logic        w_hit [NI];
  logic        w_cor [NI];
  logic [7:0]  w_cnt [NI];
  logic [57:0] w_vec [NI];

  int checks = 0;
  int errors = 0;

  // Model state and per-instance parameters.
  int mx [NI], my [NI], mxd [NI], myd [NI], mhit [NI], mcor [NI], mcnt [NI];
  int p_ix [NI] = '{320, 100, 578};
  int p_iy [NI] = '{240, 100, 240};
  int p_xd [NI] = '{1, 0, 1};
  int p_yd [NI] = '{1, 0, 1};
  int p_sp [NI] = '{1, 1, 3};

  square_bounce u_a (
    .i_clk(clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_bl(i_bl), .i_br(i_br), .i_bt(i_bt), .i_bb(i_bb),
    .o_l(w_l[0]), .o_r(w_r[0]), .o_t(w_t[0]), .o_b(w_b[0]),
    .o_hit(w_hit[0]), .o_corner(w_cor[0]), .o_hit_cnt(w_cnt[0])
  );

  square_bounce #(.IX(100), .IY(100), .IX_DIR(0), .IY_DIR(0)) u_b (
    .i_clk(clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_bl(i_bl), .i_br(i_br), .i_bt(i_bt), .i_bb(i_bb),
    .o_l(w_l[1]), .o_r(w_r[1]), .o_t(w_t[1]), .o_b(w_b[1]),
    .o_hit(w_hit[1]), .o_corner(w_cor[1]), .o_hit_cnt(w_cnt[1])
  );

  square_bounce #(.IX(578), .SPEED(3)) u_c (
    .i_clk(clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
    .i_bl(i_bl), .i_br(i_br), .i_bt(i_bt), .i_bb(i_bb),
    .o_l(w_l[2]), .o_r(w_r[2]), .o_t(w_t[2]), .o_b(w_b[2]),
    .o_hit(w_hit[2]), .o_corner(w_cor[2]), .o_hit_cnt(w_cnt[2])
  );

  for (genvar g = 0; g < NI; g++) begin : g_vec
    assign w_vec[g] = {w_l[g], w_r[g], w_t[g], w_b[g], w_hit[g], w_cor[g], w_cnt[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector from the model state of instance k.
  function automatic logic [57:0] exp_vec(input int k);
    logic [11:0] l, r, t, b;
    l = 12'(mx[k] - H);
    r = 12'(mx[k] + H);
    t = 12'(my[k] - H);
    b = 12'(my[k] + H);
    return {l, r, t, b, 1'(mhit[k]), 1'(mcor[k]), 8'(mcnt[k])};
  endfunction

  // Bounce rules for one axis on plain integers.
  function automatic void axis_model(input int p, input int d, input int lo, input int hi,
                                     input int s, output int np, output int nd,
                                     output int c);
    np = p; nd = d; c = 0;
    if (hi - lo < 2 * H) return;
    if (d == 1) begin
      if (p + s + H >= hi) begin np = hi - H; nd = 0; c = 1; end
      else np = p + s;
    end else begin
      if (p <= lo + H + s) begin np = lo + H; nd = 1; c = 1; end
      else np = p - s;
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mx[k] = p_ix[k]; my[k] = p_iy[k]; mxd[k] = p_xd[k]; myd[k] = p_yd[k];
      mhit[k] = 0; mcor[k] = 0; mcnt[k] = 0;
    end
  endtask

  // Advance one clock; the model sees the inputs present at the edge.
  task automatic tick();
    int st, bl, br, bt, bb, rs;
    int hc, vc;
    st = int'(i_ani_stb & i_animate);
    rs = int'(i_rst);
    bl = int'(i_bl); br = int'(i_br); bt = int'(i_bt); bb = int'(i_bb);
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rs != 0) begin
        mx[k] = p_ix[k]; my[k] = p_iy[k]; mxd[k] = p_xd[k]; myd[k] = p_yd[k];
        mhit[k] = 0; mcor[k] = 0; mcnt[k] = 0;
      end else if (st != 0) begin
        axis_model(mx[k], mxd[k], bl, br, p_sp[k], mx[k], mxd[k], hc);
        axis_model(my[k], myd[k], bt, bb, p_sp[k], my[k], myd[k], vc);
        mhit[k] = hc | vc;
        mcor[k] = hc & vc;
        if ((hc | vc) != 0) mcnt[k] = (mcnt[k] + 1) % 256;
      end else begin
        mhit[k] = 0; mcor[k] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b0;
    i_bl = 12'd40; i_br = 12'd600; i_bt = 12'd40; i_bb = 12'd440;
    model_reset();
    tick(); tick();
    i_rst = 1'b0;
    tick();
    checks++;
    if (w_vec[0] !== {12'd300, 12'd340, 12'd220, 12'd260, 1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL reset_a got %h want 300/340/220/260/0/0/0", w_vec[0]);
    end
    checks++;
    if (w_l[1] !== 12'd80 || w_t[1] !== 12'd80) begin
      errors++; $display("FAIL reset_b got l=%0d t=%0d want 80/80", w_l[1], w_t[1]);
    end
    checks++;
    if (w_l[2] !== 12'd558) begin
      errors++; $display("FAIL reset_c got l=%0d want 558", w_l[2]);
    end
  endtask

  // 260 strobes from reset: clamp at SPEED=3, corner bounce, vertical then
  // horizontal bounce of the default square.
  task automatic test_bounce();
    int a_hits;
    a_hits = 0;
    i_animate = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      i_ani_stb = 1'b1;
      tick();
      i_ani_stb = 1'b0;
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (w_vec[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL bounce_model inst=%0d strobe=%0d got %h want %h", k, n, w_vec[k], exp_vec(k));
        end
      end
      if (w_hit[0] === 1'b1) a_hits++;
      if (n == 1) begin
        checks++;
        if (w_r[2] !== 12'd600 || w_hit[2] !== 1'b1 || w_cor[2] !== 1'b0 || w_cnt[2] !== 8'd1) begin
          errors++;
          $display("FAIL clamp_speed3 got r=%0d hit=%b cor=%b cnt=%0d want 600/1/0/1",
                   w_r[2], w_hit[2], w_cor[2], w_cnt[2]);
        end
      end
      if (n == 40) begin
        checks++;
        if (w_l[1] !== 12'd40 || w_t[1] !== 12'd40 || w_hit[1] !== 1'b1 ||
            w_cor[1] !== 1'b1 || w_cnt[1] !== 8'd1) begin
          errors++;
          $display("FAIL corner got l=%0d t=%0d hit=%b cor=%b cnt=%0d want 40/40/1/1/1",
                   w_l[1], w_t[1], w_hit[1], w_cor[1], w_cnt[1]);
        end
      end
      if (n == 41) begin
        checks++;
        if (w_l[1] !== 12'd41 || w_t[1] !== 12'd41 || w_hit[1] !== 1'b0) begin
          errors++;
          $display("FAIL corner_after got l=%0d t=%0d hit=%b want 41/41/0", w_l[1], w_t[1], w_hit[1]);
        end
      end
      if (n == 180) begin
        checks++;
        if (w_b[0] !== 12'd440 || w_hit[0] !== 1'b1 || w_cnt[0] !== 8'd1 || a_hits != 1) begin
          errors++;
          $display("FAIL bottom_hit got b=%0d hit=%b cnt=%0d hits=%0d want 440/1/1/1",
                   w_b[0], w_hit[0], w_cnt[0], a_hits);
        end
      end
      if (n == 181) begin
        checks++;
        if (w_b[0] !== 12'd439) begin
          errors++; $display("FAIL bottom_after got b=%0d want 439", w_b[0]);
        end
      end
      if (n == 260) begin
        checks++;
        if (w_r[0] !== 12'd600 || w_hit[0] !== 1'b1 || w_cor[0] !== 1'b0 ||
            w_cnt[0] !== 8'd2 || a_hits != 2) begin
          errors++;
          $display("FAIL right_hit got r=%0d hit=%b cor=%b cnt=%0d hits=%0d want 600/1/0/2/2",
                   w_r[0], w_hit[0], w_cor[0], w_cnt[0], a_hits);
        end
      end
      tick();
      checks++;
      if (w_hit[0] !== 1'b0 || w_hit[1] !== 1'b0 || w_hit[2] !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width strobe=%0d got %b%b%b want 000", n, w_hit[0], w_hit[1], w_hit[2]);
      end
    end
  endtask

  task automatic test_freeze();
    logic [57:0] held;
    int seen_hit;
    held = w_vec[0];
    seen_hit = 0;
    i_animate = 1'b0;
    for (int n = 0; n < 50; n++) begin
      i_ani_stb = 1'b1; tick();
      i_ani_stb = 1'b0; tick();
      if (w_hit[0] !== 1'b0) seen_hit++;
    end
    i_animate = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (w_hit[0] !== 1'b0) seen_hit++;
    end
    checks++;
    if (w_vec[0] !== held || seen_hit != 0) begin
      errors++;
      $display("FAIL freeze got %h hits=%0d want %h hits=0", w_vec[0], seen_hit, held);
    end
  endtask

  task automatic test_async_reset();
    i_animate = 1'b1;
    for (int n = 0; n < 130; n++) begin
      i_ani_stb = 1'b1; tick();
      i_ani_stb = 1'b0; tick();
    end
    checks++;
    if (w_l[0] !== 12'd430 || w_cnt[0] !== 8'd2) begin
      errors++; $display("FAIL pre_reset got l=%0d cnt=%0d want 430/2", w_l[0], w_cnt[0]);
    end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (w_l[0] !== 12'd300 || w_cnt[0] !== 8'd0 || w_hit[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got l=%0d cnt=%0d hit=%b want 300/0/0", w_l[0], w_cnt[0], w_hit[0]);
    end
    model_reset();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  // Random strobes, enables and borders (including narrow and inward-moving
  // playfields) against the model every cycle.
  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        int bl, bt;
        bl = $urandom_range(0, 300);
        bt = $urandom_range(0, 300);
        i_bl = 12'(bl);
        i_bt = 12'(bt);
        i_br = 12'(bl + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 45) : $urandom_range(40, 600)));
        i_bb = 12'(bt + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 45) : $urandom_range(40, 600)));
      end
      i_ani_stb = 1'($urandom_range(0, 1));
      i_animate = 1'($urandom_range(0, 7) != 0);
      tick();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (w_vec[k] !== exp_vec(k)) begin
          errors++;
          if (bad < 10)
            $display("FAIL random inst=%0d cycle=%0d got %h want %h", k, n, w_vec[k], exp_vec(k));
          bad++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_freeze();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/square_bounce.md
Name: square_bounce

Overview:
- Moving square sprite confined to the playfield rectangle produced by the border stage; sits directly downstream of it.
- Consumes the border's four inner edges, advances once per animation strobe and reverses direction on contact.
- Outputs its own left/right/top/bottom edges for the pixel/colour stage.
- Emits a one-cycle hit pulse and a hit counter for the game/score logic.

Parameters:
H_SIZE, 20, half-width and half-height of the square in pixels
IX, 320, initial centre x after reset
IY, 240, initial centre y after reset
IX_DIR, 1, initial horizontal direction (1 = right / increasing x, 0 = left)
IY_DIR, 1, initial vertical direction (1 = down / increasing y, 0 = up)
SPEED, 1, pixels moved per axis per step (1..15)

Ports:
i_clk  in  1  base clock
i_rst  in  1  reset, asynchronous, active-high; returns square to IX/IY and IX_DIR/IY_DIR
i_ani_stb  in  1  animation strobe, one-cycle pulse per frame
i_animate  in  1  motion enable; square frozen when low
i_bl  in  12  border left edge (playfield min x)
i_br  in  12  border right edge (playfield max x)
i_bt  in  12  border top edge (playfield min y)
i_bb  in  12  border bottom edge (playfield max y)
o_l  out  12  square left edge = x - H_SIZE
o_r  out  12  square right edge = x + H_SIZE
o_t  out  12  square top edge = y - H_SIZE
o_b  out  12  square bottom edge = y + H_SIZE
o_hit  out  1  one-cycle pulse on any border contact
o_corner  out  1  one-cycle pulse when both axes make contact on the same step
o_hit_cnt  out  8  count of contact steps, wraps 255 -> 0

Behaviour:
- Clock and reset: single clock i_clk; i_rst is asynchronous, active-high.
- State: x, y (12-bit centre), x_dir, y_dir, o_hit, o_corner and o_hit_cnt registers.
- Reset values:
  - x = IX, y = IY, x_dir = IX_DIR, y_dir = IY_DIR.
  - o_hit = 0, o_corner = 0, o_hit_cnt = 0.
  - Hence o_l = IX-H_SIZE, o_r = IX+H_SIZE, o_t = IY-H_SIZE, o_b = IY+H_SIZE.
- Step condition: i_ani_stb & i_animate sampled on a rising edge; otherwise every register holds and o_hit/o_corner are 0.
- Edge outputs: combinational from x/y, so they change in the same cycle the step registers (latency 1 clock from strobe).
- Horizontal step, right (x_dir = 1):
  - if x + SPEED + H_SIZE >= i_br: x <= i_br - H_SIZE, x_dir <= 0, h_contact.
  - else x <= x + SPEED.
- Horizontal step, left (x_dir = 0):
  - if x <= i_bl + H_SIZE + SPEED: x <= i_bl + H_SIZE, x_dir <= 1, h_contact.
  - else x <= x - SPEED.
- Vertical step: identical rules using y, y_dir, i_bt, i_bb.
- Arithmetic: all comparisons use 13-bit unsigned sums, so nothing wraps.
- Contact outputs:
  - o_hit <= h_contact | v_contact.
  - o_corner <= h_contact & v_contact.
  - o_hit_cnt increments by exactly 1 per contact step, including corner steps.
- Border moved inward past the square: clamped to the new edge on the next step, with contact signalled.
- Degenerate border: if i_br - i_bl < 2*H_SIZE (or the vertical equivalent), that axis holds position and direction with no contact. This check takes priority over both move rules.
- Reset mid-motion: immediate asynchronous return to reset values; any pending hit pulse is cleared.

Test Plan:
- Border 40/600/40/440, defaults, reset released -> o_l=300, o_r=340, o_t=220, o_b=260, o_hit=0, o_hit_cnt=0.
- Same setup, i_animate=1, 180 strobes -> y=420, o_b=440, o_hit pulse on strobe 180 only, y_dir=0, o_hit_cnt=1. Strobe 181 -> o_b=439.
- Continue to strobe 260 -> x=580, o_r=600, o_hit pulse, x_dir=0, o_hit_cnt=2, o_corner=0.
- IX=IY=100, IX_DIR=IY_DIR=0, border 40/600/40/440, 40 strobes -> x=y=60 and o_l=o_t=40 on strobe 40. Single o_hit and o_corner pulse; o_hit_cnt=1; both directions flip; strobe 41 -> o_l=o_t=41.
- Freeze and hold: i_animate=0 with 50 strobes, or i_animate=1 with no strobe for 1000 cycles -> outputs unchanged, o_hit never asserted.
- Asynchronous reset mid-motion: assert i_rst between clock edges at x=450 -> o_l=300 and o_hit_cnt=0 before the next clock edge. Also: SPEED=3 toward i_br=600 from x=578 -> clamps to x=580 with contact.
